// File: rtl/id_stage_if.sv
// Bundle of fetch, register-file, writeback and ID/EX signals around the decode stage.
// The slave view belongs to id_stage; the master view belongs to its surroundings.
interface id_stage_if;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] rd_data1;
  logic [31:0] rd_data2;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_pc;
  logic [31:0] ex_op1;
  logic [31:0] ex_op2;
  logic [31:0] ex_imm;
  logic [4:0]  ex_rd;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;
  logic        ex_funct7b5;
  logic        ex_we;
  logic        ex_illegal;

  modport master (
    output if_valid, if_instr, if_pc, rd_data1, rd_data2,
           wb_valid, wb_rd, wb_data, flush, ex_ready,
    input  if_ready, rs1, rs2, ex_valid, ex_pc, ex_op1, ex_op2, ex_imm,
           ex_rd, ex_opcode, ex_funct3, ex_funct7b5, ex_we, ex_illegal
  );

  modport slave (
    input  if_valid, if_instr, if_pc, rd_data1, rd_data2,
           wb_valid, wb_rd, wb_data, flush, ex_ready,
    output if_ready, rs1, rs2, ex_valid, ex_pc, ex_op1, ex_op2, ex_imm,
           ex_rd, ex_opcode, ex_funct3, ex_funct7b5, ex_we, ex_illegal
  );
endinterface

// File: rtl/id_stage.sv
// RV32I decode stage: decode, operand bypass from writeback, busy-bit scoreboard
// for RAW/WAW interlock, and the registered ID/EX payload with valid/ready handshake.
module id_stage (
  input  logic       clk,
  input  logic       rst,
  id_stage_if.slave  bus
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;

  assign instr  = bus.if_instr;
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];

  assign bus.rs1 = rs1;
  assign bus.rs2 = rs2;

  logic        legal;
  logic        uses_rs1;
  logic        uses_rs2;
  logic        writes_rd;
  logic [31:0] imm;

  always_comb begin
    legal     = 1'b1;
    uses_rs1  = 1'b1;
    uses_rs2  = 1'b0;
    writes_rd = 1'b1;
    imm       = 32'd0;
    case (opcode)
      OP_R: begin
        uses_rs2 = 1'b1;
      end
      OP_IALU, OP_LOAD, OP_JALR: begin
        imm = {{20{instr[31]}}, instr[31:20]};
      end
      OP_STORE: begin
        uses_rs2  = 1'b1;
        writes_rd = 1'b0;
        imm       = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OP_BRANCH: begin
        uses_rs2  = 1'b1;
        writes_rd = 1'b0;
        imm       = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        uses_rs1 = 1'b0;
        imm      = {instr[31:12], 12'd0};
      end
      OP_JAL: begin
        uses_rs1 = 1'b0;
        imm      = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      default: begin
        legal     = 1'b0;
        uses_rs1  = 1'b0;
        writes_rd = 1'b0;
      end
    endcase
  end

  logic        ex_we_next;
  logic        bypass1;
  logic        bypass2;
  logic [31:0] op1;
  logic [31:0] op2;

  assign ex_we_next = writes_rd && (rd != 5'd0);
  assign bypass1    = bus.wb_valid && (bus.wb_rd == rs1);
  assign bypass2    = bus.wb_valid && (bus.wb_rd == rs2);
  assign op1 = (rs1 == 5'd0) ? 32'd0 : (bypass1 ? bus.wb_data : bus.rd_data1);
  assign op2 = (rs2 == 5'd0) ? 32'd0 : (bypass2 ? bus.wb_data : bus.rd_data2);

  logic        ex_valid_reg;
  logic [31:0] ex_pc_reg;
  logic [31:0] ex_op1_reg;
  logic [31:0] ex_op2_reg;
  logic [31:0] ex_imm_reg;
  logic [4:0]  ex_rd_reg;
  logic [6:0]  ex_opcode_reg;
  logic [2:0]  ex_funct3_reg;
  logic        ex_funct7b5_reg;
  logic        ex_we_reg;
  logic        ex_illegal_reg;
  logic [31:0] busy_reg;
  logic [31:0] busy_next;

  logic hazard;
  logic if_ready;
  logic issue;
  logic flush_clear;

  // A busy source is only a hazard if writeback is not delivering it this cycle.
  assign hazard = (uses_rs1 && busy_reg[rs1] && !bypass1)
               || (uses_rs2 && busy_reg[rs2] && !bypass2)
               || (ex_we_next && busy_reg[rd] && !(bus.wb_valid && (bus.wb_rd == rd)));

  assign if_ready    = !bus.flush && !hazard && (!ex_valid_reg || bus.ex_ready);
  assign issue       = bus.if_valid && if_ready;
  assign flush_clear = bus.flush && ex_valid_reg && ex_we_reg;
  assign bus.if_ready = if_ready;

  // Issue set beats writeback/flush clear on the same register.
  assign busy_next[0] = 1'b0;
  for (genvar gi = 1; gi < 32; gi++) begin : g_busy
    assign busy_next[gi] = (issue && ex_we_next && (rd == 5'(gi)))
                         || (busy_reg[gi]
                             && !(bus.wb_valid && (bus.wb_rd == 5'(gi)))
                             && !(flush_clear && (ex_rd_reg == 5'(gi))));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_reg <= 32'd0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_reg    <= 1'b0;
      ex_pc_reg       <= 32'd0;
      ex_op1_reg      <= 32'd0;
      ex_op2_reg      <= 32'd0;
      ex_imm_reg      <= 32'd0;
      ex_rd_reg       <= 5'd0;
      ex_opcode_reg   <= 7'd0;
      ex_funct3_reg   <= 3'd0;
      ex_funct7b5_reg <= 1'b0;
      ex_we_reg       <= 1'b0;
      ex_illegal_reg  <= 1'b0;
    end else if (issue) begin
      ex_valid_reg    <= 1'b1;
      ex_pc_reg       <= bus.if_pc;
      ex_op1_reg      <= op1;
      ex_op2_reg      <= op2;
      ex_imm_reg      <= imm;
      ex_rd_reg       <= rd;
      ex_opcode_reg   <= opcode;
      ex_funct3_reg   <= instr[14:12];
      ex_funct7b5_reg <= instr[30];
      ex_we_reg       <= ex_we_next;
      ex_illegal_reg  <= !legal;
    end else if (bus.flush || bus.ex_ready) begin
      ex_valid_reg <= 1'b0;
    end
  end

  assign bus.ex_valid    = ex_valid_reg;
  assign bus.ex_pc       = ex_pc_reg;
  assign bus.ex_op1      = ex_op1_reg;
  assign bus.ex_op2      = ex_op2_reg;
  assign bus.ex_imm      = ex_imm_reg;
  assign bus.ex_rd       = ex_rd_reg;
  assign bus.ex_opcode   = ex_opcode_reg;
  assign bus.ex_funct3   = ex_funct3_reg;
  assign bus.ex_funct7b5 = ex_funct7b5_reg;
  assign bus.ex_we       = ex_we_reg;
  assign bus.ex_illegal  = ex_illegal_reg;

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 clk  input  1  single pipeline clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 if_valid  input  1  fetch offers an instruction.
REQ-004 if_ready  output  1  stage accepts the offered instruction this cycle.
REQ-005 if_instr  input  32  instruction word; if_pc  input  32  its address.
REQ-006 rs1, rs2  output  5 each  register-file read addresses, taken combinationally from if_instr[19:15] and if_instr[24:20].
REQ-007 rd_data1, rd_data2  input  32 each  combinational register-file read data for rs1/rs2.
REQ-008 wb_valid  input  1, wb_rd  input  5, wb_data  input  32  writeback port, also driving the register-file write in the same cycle.
REQ-009 flush  input  1  discard the ID/EX entry.
REQ-010 ex_valid  output  1, ex_ready  input  1  ID/EX handshake.
REQ-011 ex_pc, ex_op1, ex_op2, ex_imm  output  32 each; ex_rd  output  5; ex_opcode  output  7; ex_funct3  output  3; ex_funct7b5  output  1; ex_we  output  1; ex_illegal  output  1  registered ID/EX payload.

Function
REQ-012 Decode classes: R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111; any other opcode is ILLEGAL.
REQ-013 Immediate: I-type (I-ALU, LOAD, JALR) sign-extended instr[31:20]; S {instr[31:25],instr[11:7]}; B {instr[31],instr[7],instr[30:25],instr[11:8],0}; U {instr[31:12],12'b0}; J {instr[31],instr[19:12],instr[20],instr[30:21],0}; all sign-extended to 32 bits; R and ILLEGAL give 0.
REQ-014 uses_rs1 for all legal classes except LUI, AUIPC, JAL; uses_rs2 only for R, STORE, BRANCH.
REQ-015 ex_we = 1 for R, I-ALU, LOAD, LUI, AUIPC, JAL, JALR with rd != 0; otherwise 0 (ILLEGAL: ex_we = 0, ex_illegal = 1).
REQ-016 Operand select per source: x0 -> 0; else wb_valid && wb_rd == rsN -> wb_data (bypass); else rd_dataN.
REQ-017 Scoreboard: 32-bit busy vector, bit 0 always 0.
REQ-018 hazard = (uses_rs1 && busy[rs1] && !bypass1) || (uses_rs2 && busy[rs2] && !bypass2) || (ex_we_next && busy[rd] && !(wb_valid && wb_rd == rd)).
REQ-019 if_ready = !flush && !hazard && (!ex_valid || ex_ready).
REQ-020 Issue = if_valid && if_ready: ID/EX payload loaded, ex_valid <= 1, busy[rd] <= 1 when ex_we_next.
REQ-021 No issue and ex_ready: ex_valid <= 0, payload held; no issue and !ex_ready: all held unchanged.
REQ-022 wb_valid clears busy[wb_rd]; a set from issue to the same register in the same cycle wins.
REQ-023 flush: ex_valid <= 0, busy[ex_rd] cleared if the flushed entry was valid with ex_we, no issue that cycle; other busy bits untouched.
REQ-024 Latency: one cycle from accepted instruction to ex_valid; back-to-back issue at one per cycle when hazard-free and ex_ready = 1.
REQ-025 Payload stable while ex_valid && !ex_ready.

Reset
REQ-026 rst asserted asynchronously forces ex_valid = 0, busy = 0, all ex_* payload outputs = 0; if_ready evaluates to 1 after reset when flush = 0.
REQ-027 Reset mid-stall or mid-handshake discards the held entry; no residual busy bits.

Verification
REQ-028 addi x5,x0,7 (0x00700293) at pc 0x100, ex_ready=1 -> next cycle ex_valid=1, ex_imm=7, ex_rd=5, ex_we=1, ex_op1=0, busy[5]=1.
REQ-029 add x6,x5,x5 following with busy[5]=1, no wb -> if_ready=0; wb_valid=1, wb_rd=5, wb_data=7 -> if_ready=1, ex_op1=ex_op2=7.
REQ-030 ex_ready=0 for 3 cycles with ex_valid=1 -> if_ready=0, payload unchanged; ex_ready=1 -> next instruction accepted in that cycle.
REQ-031 beq x1,x2,-4 (0xFE208EE3) -> ex_imm=0xFFFFFFFC, ex_we=0, no busy bit set; opcode 0x7F -> ex_illegal=1, ex_we=0.
REQ-032 flush with valid entry ex_rd=9 -> ex_valid=0, busy[9]=0, if_ready=0 that cycle; rst asserted mid-cycle -> ex_valid=0 immediately, without waiting for clk.
